// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES gamepad serial reader.
package nes_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    LOW   = 2'd2,
    HIGH  = 2'd3
  } state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // 50 MHz clock: 6 us protocol tick, 60 Hz frame rate
  localparam int unsigned DEF_TICK_CYC = 300;
  localparam int unsigned DEF_POLL_CYC = 833333;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES gamepad over latch/clock/data and publishes all 8 buttons
// together once per completed frame.
//
// state | meaning
// IDLE  | waiting for the poll wrap with enable set
// LATCH | pad_latch high for 2 ticks, pad snapshots its buttons
// LOW   | pad_clk low for 1 tick, data sampled on the last cycle
// HIGH  | pad_clk high for 1 tick, pad advances to the next bit
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int unsigned TICK_CYC = DEF_TICK_CYC,
  parameter int unsigned POLL_CYC = DEF_POLL_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       a,
  output logic       b,
  output logic       select,
  output logic       start,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic       busy
);

  localparam int unsigned PH_W   = $clog2(2 * TICK_CYC);
  localparam int unsigned POLL_W = $clog2(POLL_CYC);

  logic              sync_data;
  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        idx_q, idx_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        btn_q, btn_d;
  logic              fv_q, fv_d;
  logic              latch_q;
  logic              pclk_q;
  logic              poll_wrap;

  // Idle-high reset value: a floating pad line reads as "released".
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pad_data),
    .q_o   (sync_data)
  );

  assign poll_wrap = (poll_q == POLL_W'(POLL_CYC - 1));
  assign poll_d    = poll_wrap ? '0 : poll_q + POLL_W'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    idx_d   = idx_q;
    sr_d    = sr_q;
    btn_d   = btn_q;
    fv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (poll_wrap && enable) state_d = LATCH;
      end
      LATCH: begin
        if (phase_q == PH_W'(2 * TICK_CYC - 1)) begin
          state_d = LOW;
          phase_d = '0;
          idx_d   = '0;
        end
      end
      LOW: begin
        if (phase_q == PH_W'(TICK_CYC - 1)) begin
          sr_d[idx_q] = ~sync_data;
          phase_d     = '0;
          if (idx_q == 3'd7) begin
            state_d = IDLE;
            idx_d   = '0;
            btn_d   = sr_d;
            fv_d    = 1'b1;
          end else begin
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (phase_q == PH_W'(TICK_CYC - 1)) begin
          state_d = LOW;
          phase_d = '0;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Pad strobes decode the next state so they are flop outputs aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      sr_q    <= '0;
      btn_q   <= '0;
      fv_q    <= 1'b0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      sr_q    <= sr_d;
      btn_q   <= btn_d;
      fv_q    <= fv_d;
      latch_q <= (state_d == LATCH);
      pclk_q  <= (state_d == HIGH);
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign buttons     = btn_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != IDLE);

  assign a      = btn_q[BTN_A];
  assign b      = btn_q[BTN_B];
  assign select = btn_q[BTN_SELECT];
  assign start  = btn_q[BTN_START];
  assign up     = btn_q[BTN_UP];
  assign down   = btn_q[BTN_DOWN];
  assign left   = btn_q[BTN_LEFT];
  assign right  = btn_q[BTN_RIGHT];

endmodule
